// File: rtl/step_pattern_sequencer_pkg.sv
// Shared definitions for the step pattern sequencer: playback state encoding
// and default geometry of the pattern store.
package step_pattern_sequencer_pkg;

  localparam int NUM_STEPS = 16;
  localparam int STEP_W    = 4;
  localparam int TONE_W    = 12;

  // A Loops setting of zero keeps the pattern cycling until stop or start.
  localparam logic [6:0] LOOPS_INFINITE = 7'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/step_pattern_sequencer_if.sv
// Control, edit and playback bus of the step pattern sequencer. The master
// side drives control pulses and pattern edits; the slave side is the
// sequencer itself.
interface step_pattern_sequencer_if #(
  parameter int STEP_W = step_pattern_sequencer_pkg::STEP_W,
  parameter int TONE_W = step_pattern_sequencer_pkg::TONE_W
);

  logic              start;
  logic              stop;
  logic              Step;
  logic [6:0]        Loops;
  logic              wr_en;
  logic [STEP_W-1:0] wr_addr;
  logic [TONE_W-1:0] wr_data;
  logic              clear;
  logic              wr_ready;
  logic [TONE_W-1:0] Select;
  logic              Play;
  logic [STEP_W-1:0] step_idx;
  logic              step_strobe;
  logic              done;

  modport master (
    output start, stop, Step, Loops, wr_en, wr_addr, wr_data, clear,
    input  wr_ready, Select, Play, step_idx, step_strobe, done
  );

  modport slave (
    input  start, stop, Step, Loops, wr_en, wr_addr, wr_data, clear,
    output wr_ready, Select, Play, step_idx, step_strobe, done
  );

endinterface

// File: rtl/step_pattern_sequencer_pattern_mem.sv
// Pattern store: register array with one write port, a one-entry-per-cycle
// clear sweeper and an asynchronous read port for the playback index.
module step_pattern_sequencer_pattern_mem #(
  parameter int NUM_STEPS = step_pattern_sequencer_pkg::NUM_STEPS,
  parameter int STEP_W    = step_pattern_sequencer_pkg::STEP_W,
  parameter int TONE_W    = step_pattern_sequencer_pkg::TONE_W
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  logic [TONE_W-1:0] wr_data,
  input  logic              clear,
  input  logic [STEP_W-1:0] rd_addr,
  output logic [TONE_W-1:0] rd_data,
  output logic              wr_ready
);

  localparam logic [STEP_W-1:0] LAST_ADDR = STEP_W'(NUM_STEPS - 1);

  logic [TONE_W-1:0] mem [NUM_STEPS];
  logic              sweeping;
  logic [STEP_W-1:0] sweep_addr;

  // Sweep zeroes one entry per cycle; otherwise accept edits and start sweeps.
  // NOTE: the array is a plain register file, so reset clears it like any
  // other flop; a block-RAM store could not be reset this way.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sweeping   <= 1'b0;
      sweep_addr <= '0;
      for (int i = 0; i < NUM_STEPS; i++) mem[i] <= '0;
    end else if (sweeping) begin
      // Writes and further clear pulses are dropped while the sweep runs.
      mem[sweep_addr] <= '0;
      sweep_addr      <= sweep_addr + 1'b1;
      if (sweep_addr == LAST_ADDR) sweeping <= 1'b0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (clear) begin
        sweeping   <= 1'b1;
        sweep_addr <= '0;
      end
    end
  end

  assign wr_ready = ~sweeping;
  assign rd_data  = mem[rd_addr];

endmodule

// File: rtl/step_pattern_sequencer.sv
// Step pattern sequencer: walks the pattern store one entry per Step pulse,
// counts pattern passes and drives the registered Select/Play outputs into
// the audio generators.
module step_pattern_sequencer #(
  parameter int NUM_STEPS = step_pattern_sequencer_pkg::NUM_STEPS,
  parameter int STEP_W    = step_pattern_sequencer_pkg::STEP_W,
  parameter int TONE_W    = step_pattern_sequencer_pkg::TONE_W
) (
  input logic                     CLOCK_50,
  input logic                     reset,
  step_pattern_sequencer_if.slave bus
);

  import step_pattern_sequencer_pkg::*;

  localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(NUM_STEPS - 1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] idx_q, idx_d;
  logic [6:0]        loop_q, loop_d;
  logic              adv_q, adv_d;
  logic [TONE_W-1:0] rd_data;
  logic [TONE_W-1:0] select_q;
  logic              play_q;
  logic              strobe_q;

  step_pattern_sequencer_pattern_mem #(
    .NUM_STEPS (NUM_STEPS),
    .STEP_W    (STEP_W),
    .TONE_W    (TONE_W)
  ) u_pattern_mem (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .clear    (bus.clear),
    .rd_addr  (idx_q),
    .rd_data  (rd_data),
    .wr_ready (bus.wr_ready)
  );

  // Next state, index and pass count; stop beats start, start beats Step.
  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    loop_d  = loop_q;
    adv_d   = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      idx_d   = '0;
      loop_d  = '0;
    end else if (bus.start) begin
      state_d = PLAYING;
      idx_d   = '0;
      loop_d  = '0;
      adv_d   = 1'b1;
    end else if (state_q == PLAYING && bus.Step) begin
      adv_d = 1'b1;
      if (idx_q != LAST_IDX) begin
        idx_d = idx_q + 1'b1;
      end else begin
        idx_d  = '0;
        loop_d = loop_q + 7'd1;
        if (bus.Loops != LOOPS_INFINITE && loop_q + 7'd1 == bus.Loops)
          state_d = DONE;
      end
    end
  end

  // FSM state, index and pass counter registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      loop_q  <= '0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      loop_q  <= loop_d;
      adv_q   <= adv_d;
    end
  end

  // Output stage: one cycle behind state/idx; strobe marks a fresh step.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      select_q <= '0;
      play_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      select_q <= (state_q == PLAYING) ? rd_data : '0;
      play_q   <= (state_q == PLAYING);
      strobe_q <= adv_q && (state_q == PLAYING);
    end
  end

  assign bus.Select      = select_q;
  assign bus.Play        = play_q;
  assign bus.step_strobe = strobe_q;
  assign bus.step_idx    = idx_q;
  assign bus.done        = (state_q == DONE);

endmodule

// File: doc/step_pattern_sequencer.md
Name: step_pattern_sequencer

Overview:
Pattern store and playback engine that sits directly upstream of the audio interface. It holds a NUM_STEPS-entry pattern of 12-bit tone-select masks, advances one entry per Step pulse from the BPM counter, and drives the Select bus and a Play gate into the audio generators. It also owns loop counting for the pattern and an edit port for writing or clearing pattern entries.

Parameters:
NUM_STEPS, 16, number of pattern entries; must be a power of two ≥ 2.
STEP_W, 4, index width; equals log2(NUM_STEPS).
TONE_W, 12, width of one tone-select mask; one bit per tone.

Ports:
CLOCK_50  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; start or restart playback.
stop  in  1  one-cycle pulse; abort playback.
Step  in  1  one-cycle pulse from the BPM counter.
Loops  in  7  pattern passes to play; 0 means loop forever.
wr_en  in  1  pattern write request.
wr_addr  in  STEP_W  entry to write.
wr_data  in  TONE_W  mask to write.
clear  in  1  one-cycle pulse; zero the whole pattern.
wr_ready  out  1  high when writes are accepted.
Select  out  TONE_W  tone mask for the current step.
Play  out  1  playback-active gate.
step_idx  out  STEP_W  current step index.
step_strobe  out  1  one-cycle pulse whenever Select takes a new step's value.
done  out  1  high in DONE state.

Behaviour:
- Reset values: all outputs 0 except wr_ready = 1; state IDLE; idx 0; loop_cnt 0; pattern memory cleared to 0.
- State IDLE:
  - start → PLAYING; idx 0; loop_cnt 0.
  - Step is ignored.
- State PLAYING, on Step:
  - If idx < NUM_STEPS-1: idx + 1.
  - Else idx wraps to 0 and loop_cnt + 1.
  - If Loops ≠ 0 and loop_cnt+1 == Loops at the wrap: go to DONE instead.
  - loop_cnt is 7 bits. With Loops = 0 it wraps silently and playback continues.
- State DONE:
  - Play = 0, Select = 0, done = 1.
  - start → PLAYING with idx 0 and loop_cnt 0.
- Transition priority:
  - stop in any state → IDLE, idx 0. stop wins over a start in the same cycle.
  - start in PLAYING restarts at idx 0 and loop_cnt 0. It wins over a Step in the same cycle.
- Output timing and latency:
  - Select and Play are registered from state and idx, one cycle behind them.
  - start sampled at edge t: Play = 1 and Select = pattern[0] at edge t+1.
  - Step sampled at edge u: step_idx changes at u, Select changes at u+1, step_strobe pulses at u+1.
  - step_strobe also pulses at t+1 after a start.
- Outside PLAYING: Select = 0, Play = 0.
- Writes:
  - Accepted when wr_en & wr_ready. The memory entry updates at the next edge.
  - Writes are allowed in any state. A write to the currently playing index appears on Select within 2 cycles, with no step_strobe.
- Clear:
  - Pulse drops wr_ready and sweeps the entries 0..NUM_STEPS-1, one per cycle, taking NUM_STEPS cycles. wr_ready returns high on the cycle after the last entry.
  - wr_en during the sweep is dropped.
  - clear during a sweep is ignored.
  - Playback continues during the sweep and reads the partially cleared memory.
- reset mid-operation: everything returns immediately to reset values, including aborting a sweep and clearing the memory (a register array, not block RAM).

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, PLAYING=2'd1, DONE=2'd2);
  - default constants NUM_STEPS/STEP_W/TONE_W;
  - LOOPS_INFINITE = 7'd0.
- One natural sub-module, pattern_mem: the register array with write port, clear sweeper and wr_ready, plus an asynchronous read port on idx.
- The top level holds the FSM, step/loop counters and output registers.

Test Plan:
1. Reset: write patterns 0x001, 0x002, … to entries 0..15; start; pulse Step 3 times → Select sequence 0x001, 0x002, 0x003, 0x004, each change one cycle after Step, with a matching step_strobe pulse.
2. Loops = 2: run 32 Step pulses after start → on the 32nd Step the block enters DONE (done = 1, step_idx = 0); the next edge gives Play = 0 and Select = 0. Pulse 33 changes nothing.
3. Loops = 0: run 40 Step pulses → Play stays 1, step_idx = 8 after 40, done never asserts.
4. Control collisions: stop and start in the same cycle during PLAYING → IDLE, Play = 0 next cycle. A separate start coinciding with a Step → idx = 0, Select = pattern[0].
5. Clear in mid-play: pulse clear → wr_ready low for exactly 16 cycles; a wr_en issued during the sweep is not stored; afterwards all Select values = 0.
6. Asynchronous reset mid-play: assert reset between clock edges with idx = 5 → all outputs 0 immediately and wr_ready = 1; after release, start → Select = 0 (memory cleared).
